// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - funct3 encodings, FSM states and access checks for mem_access_ctrl
package mem_access_pkg;

    // Store encodings
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;
    // Load encodings
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        RESP    = 3'd4
    } state_t;

    // funct3[1:0] encodes access size for both loads and stores
    // (0 byte, 1 half, 2 word); bit 2 only selects zero-extension.
    function automatic logic f_is_misaligned(input logic [2:0] funct3,
                                             input logic [1:0] lane);
        logic r;
        r = 1'b0;
        case (funct3[1:0])
            2'd1:    r = lane[0];
            2'd2:    r = (lane != 2'd0);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic f_is_illegal(input logic       is_store,
                                          input logic [2:0] funct3);
        logic r;
        r = 1'b0;
        if (is_store) begin
            r = (funct3 > F3_SW);
        end else begin
            case (funct3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: r = 1'b0;
                default:                             r = 1'b1;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte/halfword merge for stores and extract/extend for loads
// Ports:
//   i_funct3    access type (store or load encoding, interpreted per output)
//   i_lane      byte address bits [1:0]
//   i_rword     word read from memory
//   i_wdata     store data
//   o_merged    word to write back (read word with lane replaced, or i_wdata for SW)
//   o_extracted load result, sign- or zero-extended
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_lane,
    input  logic [XLEN-1:0] i_rword,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_merged,
    output logic [XLEN-1:0] o_extracted
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rword[{i_lane, 3'b000} +: 8];
        w_half = i_rword[{i_lane[1], 4'b0000} +: 16];
    end

    always_comb begin
        o_merged = i_rword;
        case (i_funct3)
            F3_SB:   o_merged[{i_lane, 3'b000} +: 8]     = i_wdata[7:0];
            F3_SH:   o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            default: o_merged = i_wdata;
        endcase
    end

    always_comb begin
        o_extracted = i_rword;
        case (i_funct3)
            F3_LB:   o_extracted = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LBU:  o_extracted = {{(XLEN-8){1'b0}}, w_byte};
            F3_LH:   o_extracted = {{(XLEN-16){w_half[15]}}, w_half};
            F3_LHU:  o_extracted = {{(XLEN-16){1'b0}}, w_half};
            default: o_extracted = i_rword;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store stage to a word-only single-port memory with RMW for SB/SH
// Ports:
//   clock, reset_n                      clock and synchronous active-low reset
//   req_valid/req_ready                 request handshake (ready only in IDLE)
//   req_is_store, req_funct3,
//   req_address, req_wdata              captured request fields
//   resp_valid/resp_ready               response handshake
//   resp_rdata, resp_error              extended load data, misaligned/illegal flag
//   mem_req_valid/mem_req_ready,
//   mem_we, mem_addr, mem_wdata         word command to memory
//   mem_rvalid, mem_rdata               read return
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [XLEN-1:0]       resp_rdata,
    output logic                  resp_error,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata
);

    state_t                r_state;
    state_t                w_next;
    logic                  r_req_ready;
    logic                  r_is_store;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [XLEN-1:0]       r_wdata;
    logic [XLEN-1:0]       r_rword;
    logic                  r_error;

    logic                  w_accept;
    logic                  w_bad;
    logic [XLEN-1:0]       w_merged;
    logic [XLEN-1:0]       w_extracted;

    assign w_accept  = req_valid && r_req_ready;
    assign w_bad     = f_is_illegal(req_is_store, req_funct3) ||
                       f_is_misaligned(req_funct3, req_address[1:0]);
    assign req_ready = r_req_ready;
    assign mem_addr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};

    mem_lane_align #(.XLEN(XLEN)) u_align (
        .i_funct3    (r_funct3),
        .i_lane      (r_addr[1:0]),
        .i_rword     (r_rword),
        .i_wdata     (r_wdata),
        .o_merged    (w_merged),
        .o_extracted (w_extracted)
    );

    // req_ready is registered so it stays low through reset and rises one
    // edge after release; afterwards it tracks "state is IDLE" exactly.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
            r_is_store  <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rword     <= '0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_req_ready <= (w_next == IDLE);
            if (w_accept) begin
                r_is_store <= req_is_store;
                r_funct3   <= req_funct3;
                r_addr     <= req_address;
                r_wdata    <= req_wdata;
                r_error    <= w_bad;
            end
            if (r_state == RD_WAIT && mem_rvalid) begin
                r_rword <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_wdata     = '0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        resp_error    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_bad)
                        w_next = RESP;
                    else if (req_is_store && req_funct3 == F3_SW)
                        w_next = WR_REQ;
                    else
                        w_next = RD_REQ;
                end
            end
            RD_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) w_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rvalid) w_next = r_is_store ? WR_REQ : RESP;
            end
            WR_REQ: begin
                mem_req_valid = 1'b1;
                mem_we        = 1'b1;
                mem_wdata     = w_merged;
                if (mem_req_ready) w_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_error = r_error;
                if (!r_is_store && !r_error) resp_rdata = w_extracted;
                if (resp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed table-driven bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        auto_rv;
    logic        r_rv;
    logic        man_rv;
    logic [31:0] mem_word;

    int n_chk  = 0;
    int n_fail = 0;

    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          mreq_cnt = 0;
    logic [31:0] last_rd_addr = '0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    assign mem_rvalid = auto_rv ? r_rv : man_rv;
    assign mem_rdata  = mem_word;

    mem_access_ctrl #(.XLEN(32), .ADDR_WIDTH(32)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_is_store  (req_is_store),
        .req_funct3    (req_funct3),
        .req_address   (req_address),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_error    (resp_error),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    // Memory model: counts accepted commands at the active edge and returns
    // read data (mem_word) one cycle after a read is accepted.
    initial begin : mem_model
        bit pend;
        pend = 1'b0;
        r_rv = 1'b0;
        forever begin
            @(posedge clock);
            if (reset_n && mem_req_valid) begin
                mreq_cnt++;
                if (mem_req_ready) begin
                    if (mem_we) begin
                        wr_cnt++;
                        last_wr_addr = mem_addr;
                        last_wr_data = mem_wdata;
                    end else begin
                        rd_cnt++;
                        last_rd_addr = mem_addr;
                        pend = 1'b1;
                    end
                end
            end
            @(negedge clock);
            r_rv = pend;
            pend = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_wword;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic drive_req(input logic is_st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_is_store = is_st;
        req_funct3   = f3;
        req_address  = addr;
        req_wdata    = wd;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int rd0, wr0, mq0, lat, k;
        mem_word = v.word;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        mq0 = mreq_cnt;
        @(negedge clock);
        drive_req(v.is_st, v.f3, v.addr, v.wdata);
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        chk({tag, " latency"}, lat, v.exp_lat);
        chk({tag, " rdata"}, resp_rdata, v.exp_rdata);
        chk({tag, " error"}, {31'd0, resp_error}, {31'd0, v.exp_err});
        chk({tag, " reads"}, rd_cnt - rd0, v.exp_rd);
        chk({tag, " writes"}, wr_cnt - wr0, v.exp_wr);
        if (v.exp_rd != 0) chk({tag, " rd addr"}, last_rd_addr, v.addr & 32'hFFFF_FFFC);
        if (v.exp_wr != 0) begin
            chk({tag, " wr addr"}, last_wr_addr, v.addr & 32'hFFFF_FFFC);
            chk({tag, " wr data"}, last_wr_data, v.exp_wword);
        end
        if (v.exp_err) chk({tag, " no mem cmd"}, mreq_cnt - mq0, 0);
        @(posedge clock);
    endtask

    initial begin : main
        int rd0, wr0, mq0, k;
        vec_t lw_v;

        reset_n       = 1'b0;
        req_valid     = 1'b0;
        req_is_store  = 1'b0;
        req_funct3    = 3'd0;
        req_address   = '0;
        req_wdata     = '0;
        resp_ready    = 1'b1;
        mem_req_ready = 1'b1;
        auto_rv       = 1'b1;
        man_rv        = 1'b0;
        mem_word      = '0;

        //          st    f3    addr          wdata         word          rdata         err  lat rd wr wword
        vecs[0]  = '{1'b1, 3'd0, 32'h0000_1002, 32'h0000_00AB, 32'h1122_3344, 32'h0,        1'b0, 4, 1, 1, 32'h11AB_3344};
        vecs[1]  = '{1'b0, 3'd0, 32'h0000_1003, 32'h0,         32'h80FF_0000, 32'hFFFF_FF80, 1'b0, 3, 1, 0, 32'h0};
        vecs[2]  = '{1'b0, 3'd4, 32'h0000_1003, 32'h0,         32'h80FF_0000, 32'h0000_0080, 1'b0, 3, 1, 0, 32'h0};
        vecs[3]  = '{1'b0, 3'd5, 32'h0000_1002, 32'h0,         32'h80FF_0000, 32'h0000_80FF, 1'b0, 3, 1, 0, 32'h0};
        vecs[4]  = '{1'b0, 3'd1, 32'h0000_1002, 32'h0,         32'h80FF_0000, 32'hFFFF_80FF, 1'b0, 3, 1, 0, 32'h0};
        vecs[5]  = '{1'b0, 3'd2, 32'h0000_1000, 32'h0,         32'h80FF_0000, 32'h80FF_0000, 1'b0, 3, 1, 0, 32'h0};
        vecs[6]  = '{1'b1, 3'd2, 32'h0000_2000, 32'hDEAD_BEEF, 32'h5555_5555, 32'h0,         1'b0, 2, 0, 1, 32'hDEAD_BEEF};
        vecs[7]  = '{1'b1, 3'd1, 32'h0000_1001, 32'h0000_1234, 32'h1122_3344, 32'h0,         1'b1, 1, 0, 0, 32'h0};
        vecs[8]  = '{1'b1, 3'd2, 32'h0000_2002, 32'hDEAD_BEEF, 32'h1122_3344, 32'h0,         1'b1, 1, 0, 0, 32'h0};
        vecs[9]  = '{1'b1, 3'd1, 32'h0000_1002, 32'h1234_CAFE, 32'h1122_3344, 32'h0,         1'b0, 4, 1, 1, 32'hCAFE_3344};
        vecs[10] = '{1'b1, 3'd1, 32'h0000_1000, 32'h0000_BEEF, 32'h1122_3344, 32'h0,         1'b0, 4, 1, 1, 32'h1122_BEEF};
        vecs[11] = '{1'b1, 3'd0, 32'h0000_1000, 32'h0000_0055, 32'h1122_3344, 32'h0,         1'b0, 4, 1, 1, 32'h1122_3355};
        vecs[12] = '{1'b1, 3'd0, 32'h0000_1001, 32'hFFFF_FF66, 32'hAABB_CCDD, 32'h0,         1'b0, 4, 1, 1, 32'hAABB_66DD};
        vecs[13] = '{1'b0, 3'd0, 32'h0000_1000, 32'h0,         32'h0000_007F, 32'h0000_007F, 1'b0, 3, 1, 0, 32'h0};
        vecs[14] = '{1'b0, 3'd5, 32'h0000_1000, 32'h0,         32'h1234_ABCD, 32'h0000_ABCD, 1'b0, 3, 1, 0, 32'h0};
        vecs[15] = '{1'b0, 3'd1, 32'h0000_1003, 32'h0,         32'h1234_ABCD, 32'h0,         1'b1, 1, 0, 0, 32'h0};
        vecs[16] = '{1'b0, 3'd2, 32'h0000_1001, 32'h0,         32'h1234_ABCD, 32'h0,         1'b1, 1, 0, 0, 32'h0};
        vecs[17] = '{1'b1, 3'd4, 32'h0000_1000, 32'h0000_00FF, 32'h1234_ABCD, 32'h0,         1'b1, 1, 0, 0, 32'h0};
        vecs[18] = '{1'b0, 3'd3, 32'h0000_1000, 32'h0,         32'h1234_ABCD, 32'h0,         1'b1, 1, 0, 0, 32'h0};
        vecs[19] = '{1'b0, 3'd6, 32'h0000_1000, 32'h0,         32'h1234_ABCD, 32'h0,         1'b1, 1, 0, 0, 32'h0};

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset ctl", {27'd0, req_ready, mem_req_valid, mem_we, resp_valid, resp_error}, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("req_ready after reset", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Memory command backpressure: SW held for 3 cycles
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(negedge clock);
        mem_req_ready = 1'b0;
        drive_req(1'b1, 3'd2, 32'h0000_3004, 32'hA5A5_A5A5);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp%0d mem_req_valid", i), {31'd0, mem_req_valid}, 32'd1);
            chk($sformatf("bp%0d mem_we", i), {31'd0, mem_we}, 32'd1);
            chk($sformatf("bp%0d mem_addr", i), mem_addr, 32'h0000_3004);
            chk($sformatf("bp%0d mem_wdata", i), mem_wdata, 32'hA5A5_A5A5);
            if (i < 2) @(negedge clock);
        end
        mem_req_ready = 1'b1;
        @(negedge clock);
        chk("bp resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("bp writes", wr_cnt - wr0, 1);
        chk("bp reads", rd_cnt - rd0, 0);
        @(posedge clock);

        // Response backpressure: LW held for 5 cycles
        mem_word = 32'hCAFE_F00D;
        @(negedge clock);
        resp_ready = 1'b0;
        drive_req(1'b0, 3'd2, 32'h0000_4000, 32'h0);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        k = 0;
        while (!resp_valid && k < 20) begin
            @(negedge clock);
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rbp%0d resp_valid", i), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("rbp%0d resp_rdata", i), resp_rdata, 32'hCAFE_F00D);
            chk($sformatf("rbp%0d req_ready", i), {31'd0, req_ready}, 32'd0);
            @(negedge clock);
        end
        resp_ready = 1'b1;
        @(negedge clock);
        chk("rbp released resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rbp released req_ready", {31'd0, req_ready}, 32'd1);

        // Reset during RD_WAIT of an SB, then a late rvalid
        auto_rv  = 1'b0;
        mem_word = 32'h1122_3344;
        @(negedge clock);
        drive_req(1'b1, 3'd0, 32'h0000_1002, 32'h0000_00AB);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        chk("rst RD_REQ mem_req_valid", {31'd0, mem_req_valid}, 32'd1);
        @(negedge clock);
        chk("rst RD_WAIT mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        reset_n = 1'b0;
        @(negedge clock);
        chk("rst mid ctl", {27'd0, req_ready, mem_req_valid, mem_we, resp_valid, resp_error}, 32'd0);
        chk("rst mid mem_addr", mem_addr, 32'd0);
        chk("rst mid mem_wdata", mem_wdata, 32'd0);
        chk("rst mid resp_rdata", resp_rdata, 32'd0);
        wr0 = wr_cnt;
        mq0 = mreq_cnt;
        reset_n = 1'b1;
        man_rv  = 1'b1;
        @(negedge clock);
        man_rv = 1'b0;
        repeat (4) @(negedge clock);
        chk("late rvalid writes", wr_cnt - wr0, 0);
        chk("late rvalid mem cmds", mreq_cnt - mq0, 0);
        chk("late rvalid req_ready", {31'd0, req_ready}, 32'd1);
        chk("late rvalid resp_valid", {31'd0, resp_valid}, 32'd0);
        auto_rv = 1'b1;
        lw_v = '{1'b0, 3'd2, 32'h0000_5008, 32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 3, 1, 0, 32'h0};
        run_vec("post-reset lw", lw_v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-side stage directly downstream of the execute-stage store unit and its load counterpart.
- Takes one load/store request per transaction: funct3, effective address and store data.
- Performs word-aligned accesses to a single-port memory that has no byte strobes. SB/SH are done as read-modify-write.
- Returns load data sign- or zero-extended, flags misaligned accesses, and handshakes both sides with valid/ready.

Parameters:
- XLEN, 32, data path and register width.
- ADDR_WIDTH, 32, byte address width. The memory address is word-aligned, with bits [1:0] always 0.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  stage can accept a request; high only in IDLE.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  store: SB=0, SH=1, SW=2. Load: LB=0, LH=1, LW=2, LBU=4, LHU=5.
- req_address  in  ADDR_WIDTH  effective byte address (operand1 + immediate).
- req_wdata  in  XLEN  store data (rs2).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  XLEN  extended load result; 0 for stores.
- resp_error  out  1  misaligned access or illegal funct3.
- mem_req_valid  out  1  memory command valid.
- mem_req_ready  in  1  memory accepts the command.
- mem_we  out  1  1 = write word, 0 = read word.
- mem_addr  out  ADDR_WIDTH  {req_address[ADDR_WIDTH-1:2], 2'b00}.
- mem_wdata  out  XLEN  full write word.
- mem_rvalid  in  1  read data valid; one pulse per read command, 1 or more cycles after acceptance.
- mem_rdata  in  XLEN  read data.

Behaviour:
- Reset, with reset_n low at a rising edge:
  - State goes to IDLE.
  - All outputs go to 0, except req_ready, which becomes 1 in the cycle after reset releases.
  - Captured registers are cleared.
  - Reset mid-transaction abandons it. No write is issued, and a mem_rvalid arriving in IDLE is ignored.
- Capture: on req_valid && req_ready, latch is_store, funct3, address and wdata. Next state depends on checks:
  - misaligned or illegal funct3: RESP with error=1, and no memory command is ever issued;
  - SW aligned: WR_REQ;
  - otherwise: RD_REQ.
- Misaligned rules:
  - SH/LH/LHU with addr[0]=1 is misaligned.
  - SW/LW with addr[1:0]!=0 is misaligned.
  - Byte accesses are never misaligned.
  - Store funct3 >2 and load funct3 3, 6 or 7 are illegal.
- States:
  - IDLE: waiting for a request.
  - RD_REQ: mem_req_valid=1, mem_we=0. Move to RD_WAIT on mem_req_ready.
  - RD_WAIT: on mem_rvalid, latch mem_rdata. Then go to WR_REQ for a store, or RESP for a load.
  - WR_REQ: mem_req_valid=1, mem_we=1, mem_wdata = merged word. Move to RESP on mem_req_ready; the write is complete on acceptance.
  - RESP: resp_valid=1, held stable with data and error. Return to IDLE on resp_ready.
- mem_req_valid, mem_addr, mem_we and mem_wdata hold stable until mem_req_ready is high.
- Lane index: b = addr[1:0], h = addr[1].
- Merge (store):
  - SB replaces byte b of the read word with wdata[7:0].
  - SH replaces halfword h with wdata[15:0].
  - SW writes wdata unchanged.
- Extract (load):
  - LB/LBU select byte b and sign-/zero-extend it to XLEN.
  - LH/LHU select halfword h and extend likewise.
  - LW passes the word through.
- Latency, with memory ready tied to 1 and rvalid 1 cycle after acceptance:
  - Accept is cycle T.
  - SW: write command at T+1, resp_valid at T+2.
  - Load: read command at T+1, rvalid at T+2, resp_valid at T+3.
  - SB/SH: read at T+1, rvalid at T+2, write at T+3, resp_valid at T+4.
- Only one transaction is outstanding. req_ready=0 outside IDLE; there is no request/response overlap.

Decomposition:
- Package mem_access_pkg holds:
  - funct3 constants SB/SH/SW and LB/LH/LW/LBU/LHU;
  - the state enum IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP;
  - a misalignment helper function.
- Sub-module mem_lane_align: combinational merge/extract given funct3, addr[1:0], read word and wdata. The FSM stays in the top module.

Test Plan:
- SB addr 0x1002 wdata 0x000000AB, memory word 0x11223344 → read 0x1000, then write 0x1000 data 0x11AB3344; resp_error=0.
- LB addr 0x1003, word 0x80FF0000 → resp_rdata 0xFFFFFF80. LBU on the same word → 0x00000080. LHU addr 0x1002 → 0x000080FF.
- SW addr 0x2000 wdata 0xDEADBEEF, mem ready tied 1 → single write with no read; resp_valid exactly 2 cycles after accept.
- SH addr 0x1001 → resp_error=1 in RESP; mem_req_valid never asserted. SW addr 0x2002 → same.
- Backpressure:
  - mem_req_ready low for 3 cycles → mem_req_valid, mem_addr and mem_wdata stay stable.
  - resp_ready low for 5 cycles → resp_valid and resp_rdata stay stable; req_ready stays 0.
- Reset_n low during RD_WAIT of an SB:
  - Next cycle state is IDLE and outputs are 0.
  - A late mem_rvalid produces no write.
  - A new LW then completes normally.
